// File: rtl/shift_norm_pkg.sv
// Shared types and sizing for the iterative left-normaliser (shift_norm).
package shift_norm_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // state | meaning
  // IDLE  | ready for an operand (i_ready=1)
  // SHIFT | shifting work register left one bit per cycle
  // DONE  | result presented, waiting for o_ready
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int shamt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/shift_norm_if.sv
// Operand/result handshake bundle for shift_norm; master drives operands, slave is the normaliser.
interface shift_norm_if
  import shift_norm_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SHAMT_WIDTH = shamt_width(WIDTH)
) ();

  logic [WIDTH-1:0]       i_1;
  logic                   i_valid;
  logic                   i_ready;
  logic [WIDTH-1:0]       o;
  logic [SHAMT_WIDTH-1:0] o_shamt;
  logic                   o_zero;
  logic                   o_valid;
  logic                   o_ready;

  modport master (
    output i_1, i_valid, o_ready,
    input  i_ready, o, o_shamt, o_zero, o_valid
  );

  modport slave (
    input  i_1, i_valid, o_ready,
    output i_ready, o, o_shamt, o_zero, o_valid
  );

endinterface

// File: rtl/shift_norm.sv
// Iterative left-normaliser: shifts the operand left until its MSB is set, reporting the shift count.
// Optional macro SHIFT_NORM_ENABLE_PIN_EN adds an enable input that forces a zero result when low.
module shift_norm
  import shift_norm_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SHAMT_WIDTH = shamt_width(WIDTH)
) (
  input  logic clk,
  input  logic rst,
`ifdef SHIFT_NORM_ENABLE_PIN_EN
  input  logic enable,
`endif
  shift_norm_if.slave bus
);

  state_t                 r_state;
  state_t                 w_next;
  logic [WIDTH-1:0]       r_work;
  logic [SHAMT_WIDTH-1:0] r_cnt;
  logic                   r_zero;

  logic w_en;
  logic w_accept;
  logic w_op_zero;
  logic w_op_msb;
  logic w_last_shift;

`ifdef SHIFT_NORM_ENABLE_PIN_EN
  assign w_en = enable;
`else
  assign w_en = 1'b1;
`endif

  assign w_accept     = (r_state == IDLE) && bus.i_valid;
  assign w_op_zero    = (bus.i_1 == '0);
  assign w_op_msb     = bus.i_1[WIDTH-1];
  // The bit about to become the MSB decides whether this is the final shift.
  assign w_last_shift = r_work[WIDTH-2];

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.i_valid) begin
          w_next = (!w_en || w_op_zero || w_op_msb) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (w_last_shift) begin
          w_next = DONE;
        end
      end
      DONE: begin
        if (bus.o_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_work <= '0;
      r_cnt  <= '0;
      r_zero <= 1'b0;
    end else if (w_accept) begin
      r_work <= w_en ? bus.i_1 : '0;
      r_cnt  <= '0;
      r_zero <= w_en && w_op_zero;
    end else if (r_state == SHIFT) begin
      r_work <= r_work << 1;
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  assign bus.i_ready = (r_state == IDLE);
  assign bus.o_valid = (r_state == DONE);
  assign bus.o       = r_work;
  assign bus.o_shamt = r_cnt;
  assign bus.o_zero  = r_zero;

endmodule
